// File: rtl/q_pkg.sv
// Shared definitions for the Q-flop handshake front end: FSM encoding,
// synchronizer default depth and a constant-evaluable clog2.
package q_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      SETUP = 3'd1,
      REQ   = 3'd2,
      RTZ   = 3'd3,
      ERR   = 3'd4
   } q_state_t;

   localparam int SYNC_STAGES_DEF = 2;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      for (int i = 1; i < v; i = i * 2) r++;
      return r;
   endfunction

endpackage

// File: rtl/q_sync_ff.sv
// Multi-flop synchronizer for a single asynchronous level; output is the
// input delayed by STAGES clocks.
module q_sync_ff
   import q_pkg::*;
#(
   parameter int STAGES = SYNC_STAGES_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] sync_pipe;

   always_ff @(posedge clk) begin
      if (!rst) sync_pipe <= '0;
      else      sync_pipe <= {sync_pipe[STAGES-2:0], d};
   end

   assign q = sync_pipe[STAGES-1];

endmodule

// File: rtl/q_sync_tx.sv
// Clocked transmitter: buffers words from a valid/ready port and issues one
// four-phase return-to-zero handshake per word on r_out/a_in.
module q_sync_tx
   import q_pkg::*;
#(
   parameter int WIDTH       = 8,
   parameter int DEPTH       = 4,
   parameter int SYNC_STAGES = SYNC_STAGES_DEF,
   parameter int TIMEOUT     = 255
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [WIDTH-1:0]         in_data,
   output logic                     r_out,
   input  logic                     a_in,
   output logic [WIDTH-1:0]         d_out,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     err_timeout
);

   localparam int AW = clog2(DEPTH);
   localparam int LW = AW + 1;
   localparam int TW = clog2(TIMEOUT + 1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr, rd_ptr;
   logic [TW-1:0]    tcnt;
   q_state_t         state;
   logic             ack_s, full, push, pop, tmo;

   q_sync_ff #(.STAGES(SYNC_STAGES)) u_ack_sync (
      .clk (clk),
      .rst (rst),
      .d   (a_in),
      .q   (ack_s)
   );

   assign full     = (level == LW'(DEPTH));
   assign in_ready = !full && (state != ERR);
   assign push     = in_valid && in_ready;
   assign pop      = (state == REQ) && ack_s;
   // tcnt counts completed cycles in the phase; this cycle is the TIMEOUT-th
   assign tmo      = (tcnt == TW'(TIMEOUT - 1));

   always_ff @(posedge clk) begin
      if (rst && push) mem[wr_ptr] <= in_data;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state       <= IDLE;
         r_out       <= 1'b0;
         d_out       <= '0;
         level       <= '0;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         tcnt        <= '0;
         err_timeout <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         if (push && !pop)      level <= level + 1'b1;
         else if (pop && !push) level <= level - 1'b1;

         case (state)
            // A still-high ack belongs to a previous handshake; wait it out
            IDLE: begin
               if (level != '0 && !ack_s) begin
                  d_out <= mem[rd_ptr];
                  state <= SETUP;
               end
            end
            SETUP: begin
               r_out <= 1'b1;
               tcnt  <= '0;
               state <= REQ;
            end
            REQ: begin
               if (ack_s) begin
                  r_out <= 1'b0;
                  tcnt  <= '0;
                  state <= RTZ;
               end else if (tmo) begin
                  r_out       <= 1'b0;
                  err_timeout <= 1'b1;
                  state       <= ERR;
               end else begin
                  tcnt <= tcnt + 1'b1;
               end
            end
            RTZ: begin
               if (!ack_s) begin
                  state <= IDLE;
               end else if (tmo) begin
                  err_timeout <= 1'b1;
                  state       <= ERR;
               end else begin
                  tcnt <= tcnt + 1'b1;
               end
            end
            ERR: begin
               r_out       <= 1'b0;
               err_timeout <= 1'b1;
            end
            default: begin
               r_out <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_q_sync_tx.sv
// Directed and randomized bench for q_sync_tx with a behavioural stage
// responder and a queue-based reference of words in flight.
module tb_q_sync_tx;

   localparam int WIDTH = 8;
   localparam int DEPTH = 4;
   localparam int SYNC  = 2;
   localparam int TMO   = 10;

   logic             clk, rst, in_valid, in_ready, r_out, a_in, err_timeout;
   logic [WIDTH-1:0] in_data, d_out;
   logic [2:0]       level;

   int checks = 0;
   int fails  = 0;
   int hs_done = 0;
   logic [WIDTH-1:0] exp_q [$];

   // responder control: when resp_mode=1, a_in follows r_out after a random delay
   logic resp_mode;
   int   resp_min, resp_max;

   q_sync_tx #(.WIDTH(WIDTH), .DEPTH(DEPTH), .SYNC_STAGES(SYNC), .TIMEOUT(TMO)) dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_data     (in_data),
      .r_out       (r_out),
      .a_in        (a_in),
      .d_out       (d_out),
      .level       (level),
      .err_timeout (err_timeout)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Stage model: answers the current r_out level a few clocks after it changes
   initial begin
      int d;
      forever begin
         @(negedge clk);
         if (resp_mode === 1'b1 && r_out !== a_in) begin
            d = $urandom_range(resp_max, resp_min);
            repeat (d - 1) @(negedge clk);
            if (resp_mode === 1'b1) a_in = r_out;
         end
      end
   end

   // Reference tracking: a word leaves the queue when its request completes
   logic prev_r = 1'b0;
   logic [WIDTH-1:0] prev_d = '0;
   always @(posedge clk) begin
      #2;
      if (rst !== 1'b1) begin
         prev_r = r_out;
      end else begin
         if (r_out && !prev_r) begin
            chk("req_nonempty", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) chk("d_order", 32'(d_out), 32'(exp_q[0]));
            chk("d_setup", 32'(d_out), 32'(prev_d));
         end
         if (r_out && prev_r) chk("d_hold", 32'(d_out), 32'(prev_d));
         if (!r_out && prev_r && !err_timeout) begin
            if (exp_q.size() != 0) void'(exp_q.pop_front());
            hs_done++;
         end
         chk("level", 32'(level), 32'(exp_q.size()));
         prev_r = r_out;
      end
      prev_d = d_out;
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic push(input logic [WIDTH-1:0] w);
      int n;
      n = 0;
      in_valid = 1'b1;
      in_data  = w;
      while (!in_ready && n < 400) begin
         @(negedge clk);
         n++;
      end
      chk("push_accept", 32'(n < 400), 32'd1);
      @(posedge clk);
      if (in_ready) exp_q.push_back(w);
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic wait_r(input logic v, input string tag);
      int n;
      n = 0;
      while (r_out !== v && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk(tag, 32'(r_out), 32'(v));
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while ((level != 0 || r_out || a_in) && n < 1000) begin
         @(negedge clk);
         n++;
      end
      tick(2 * SYNC + 4);
      chk("idle_level", 32'(level), 32'd0);
      chk("idle_r", 32'(r_out), 32'd0);
   endtask

   task automatic do_reset();
      rst = 1'b0;
      exp_q.delete();
      tick(2);
      rst = 1'b1;
      tick(1);
   endtask

   initial begin
      int hs0;
      logic ok;
      logic [WIDTH-1:0] w;
      rst = 1'b0; in_valid = 1'b0; in_data = '0; a_in = 1'b0;
      resp_mode = 1'b0; resp_min = 3; resp_max = 3;

      // reset state
      tick(3);
      chk("rst_r", 32'(r_out), 32'd0);
      chk("rst_d", 32'(d_out), 32'd0);
      chk("rst_level", 32'(level), 32'd0);
      chk("rst_err", 32'(err_timeout), 32'd0);
      chk("rst_ready", 32'(in_ready), 32'd1);
      rst = 1'b1;
      tick(1);

      // single word: request exactly 2 clk after push, data already stable
      resp_mode = 1'b1;
      hs0 = hs_done;
      push(8'hA5);
      chk("a5_level", 32'(level), 32'd1);
      chk("a5_r0", 32'(r_out), 32'd0);
      tick(1);
      chk("a5_setup_r", 32'(r_out), 32'd0);
      chk("a5_setup_d", 32'(d_out), 32'hA5);
      tick(1);
      chk("a5_req_r", 32'(r_out), 32'd1);
      chk("a5_req_d", 32'(d_out), 32'hA5);
      wait_idle();
      chk("a5_hs", 32'(hs_done - hs0), 32'd1);

      // fill to DEPTH; fifth push waits for first pop
      for (int i = 1; i <= 4; i++) push(8'(i));
      chk("full_ready", 32'(in_ready), 32'd0);
      chk("full_level", 32'(level), 32'd4);
      hs0 = hs_done;
      push(8'h05);
      chk("fifth_after_pop", 32'(hs_done - hs0), 32'd1);
      chk("fifth_level", 32'(level), 32'd4);
      wait_idle();

      // push on the pop edge with level=2, six times across pointer wrap
      resp_mode = 1'b0;
      a_in = 1'b0;
      push(8'($urandom));
      push(8'($urandom));
      for (int i = 0; i < 6; i++) begin
         wait_r(1'b1, "sp_req");
         a_in = 1'b1;
         tick(2);
         chk("sp_pre_level", 32'(level), 32'd2);
         w = 8'($urandom);
         in_valid = 1'b1;
         in_data  = w;
         @(posedge clk);
         exp_q.push_back(w);
         @(negedge clk);
         in_valid = 1'b0;
         chk("sp_level", 32'(level), 32'd2);
         chk("sp_r_fall", 32'(r_out), 32'd0);
         a_in = 1'b0;
      end
      resp_mode = 1'b1;
      wait_idle();

      // randomized stream with random gaps and stage delays
      resp_min = 1; resp_max = 5;
      for (int i = 0; i < 24; i++) begin
         push(8'($urandom));
         tick($urandom_range(3, 0));
      end
      wait_idle();

      // timeout: ack never arrives
      resp_mode = 1'b0;
      a_in = 1'b0;
      push(8'h3C);
      wait_r(1'b1, "to_req");
      tick(TMO - 1);
      chk("to_r_before", 32'(r_out), 32'd1);
      tick(1);
      chk("to_r", 32'(r_out), 32'd0);
      chk("to_err", 32'(err_timeout), 32'd1);
      chk("to_ready", 32'(in_ready), 32'd0);
      chk("to_level", 32'(level), 32'd1);
      a_in = 1'b1;
      tick(6);
      a_in = 1'b0;
      tick(6);
      chk("to_sticky", 32'(err_timeout), 32'd1);
      chk("to_no_req", 32'(r_out), 32'd0);
      do_reset();
      chk("to_clear_err", 32'(err_timeout), 32'd0);
      chk("to_clear_level", 32'(level), 32'd0);
      chk("to_clear_ready", 32'(in_ready), 32'd1);

      // reset mid-request drops r_out and discards buffered words
      push(8'h11);
      push(8'h22);
      wait_r(1'b1, "mr_req");
      rst = 1'b0;
      exp_q.delete();
      tick(1);
      chk("mr_r", 32'(r_out), 32'd0);
      chk("mr_level", 32'(level), 32'd0);
      rst = 1'b1;
      ok = 1'b1;
      repeat (20) begin
         @(negedge clk);
         if (r_out !== 1'b0) ok = 1'b0;
      end
      chk("mr_quiet", 32'(ok), 32'd1);

      // stale ack high at reset release holds FSM in IDLE
      a_in = 1'b1;
      do_reset();
      push(8'h77);
      tick(8);
      chk("stale_r", 32'(r_out), 32'd0);
      chk("stale_d", 32'(d_out), 32'd0);
      chk("stale_level", 32'(level), 32'd1);
      hs0 = hs_done;
      a_in = 1'b0;
      resp_mode = 1'b1;
      wait_r(1'b1, "stale_req");
      chk("stale_req_d", 32'(d_out), 32'h77);
      wait_idle();
      chk("stale_hs", 32'(hs_done - hs0), 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end

endmodule
